// File: rtl/gb_interrupt_ctrl.sv
// gb_interrupt_ctrl: IF/IE registers, fixed-priority grant FSM, ISR vector.
// Optional build macro IRQ_EDGE_DETECT_EN: int_src sampled as levels.
module gb_interrupt_ctrl #(
   parameter logic [15:0] IF_ADDR  = 16'hFF0F,
   parameter logic [15:0] IE_ADDR  = 16'hFFFF,
   parameter logic [7:0]  VEC_BASE = 8'h40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        rd,
   input  logic        wr,
   output logic [7:0]  rdata,
   output logic        rvalid,
   input  logic [4:0]  int_src,
   output logic        irq,
   input  logic        int_ack,
   output logic [7:0]  vector,
   output logic        vec_valid
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [4:0]  r_if;
   logic [4:0]  w_if_nxt;
   logic [7:0]  r_ie;
   logic [2:0]  r_sel;
   logic        r_none;
   logic        r_rvalid;
   logic [7:0]  r_rdata;

   logic [4:0]  w_evt;
   logic [4:0]  w_pend;
   logic [2:0]  w_enc;
   logic [4:0]  w_clr;
   logic        w_vec_valid;
   logic [7:0]  w_vector;
   logic        w_if_hit;
   logic        w_ie_hit;

   assign w_if_hit = (addr == IF_ADDR);
   assign w_ie_hit = (addr == IE_ADDR);
   assign w_pend   = r_ie[4:0] & r_if;

`ifdef IRQ_EDGE_DETECT_EN
   logic [4:0] r_src_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_q <= 5'h00;
      end else begin
         r_src_q <= int_src;
      end
   end

   assign w_evt = int_src & ~r_src_q;
`else
   assign w_evt = int_src;
`endif

   // Lowest pending index wins; bit 0 has highest priority.
   always_comb begin
      w_enc = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (w_pend[i]) begin
            w_enc = 3'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs are masked by reset so an aborted grant never pulses.
   always_comb begin
      w_state_nxt = r_state;
      w_vec_valid = 1'b0;
      w_vector    = 8'h00;
      w_clr       = 5'h00;
      unique case (r_state)
         S_IDLE: begin
            if (int_ack) begin
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            w_state_nxt = S_IDLE;
            if (!reset) begin
               w_vec_valid = 1'b1;
               if (!r_none) begin
                  w_vector = VEC_BASE + {2'b00, r_sel, 3'b000};
                  w_clr    = 5'b00001 << r_sel;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel  <= 3'd0;
         r_none <= 1'b1;
      end else if (r_state == S_IDLE && int_ack) begin
         r_sel  <= w_enc;
         r_none <= (w_pend == 5'h00);
      end
   end

   // CPU write first, then grant clear, then source events on top.
   always_comb begin
      w_if_nxt = r_if;
      if (wr && w_if_hit) begin
         w_if_nxt = wdata[4:0];
      end
      w_if_nxt = (w_if_nxt & ~w_clr) | w_evt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_if <= 5'h00;
         r_ie <= 8'h00;
      end else begin
         r_if <= w_if_nxt;
         if (wr && w_ie_hit) begin
            r_ie <= wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 8'h00;
      end else begin
         r_rvalid <= 1'b0;
         if (rd && w_if_hit) begin
            r_rvalid <= 1'b1;
            r_rdata  <= {3'b111, r_if};
         end else if (rd && w_ie_hit) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_ie;
         end
      end
   end

   assign rdata     = r_rdata;
   assign rvalid    = r_rvalid;
   assign irq       = |w_pend;
   assign vector    = w_vector;
   assign vec_valid = w_vec_valid;

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb_gb_interrupt_ctrl: table-driven bus/IRQ vectors with rdata and vector
// scoreboards, plus hand sequences for grant-clear and reset-abort cases.
module tb_gb_interrupt_ctrl;

   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;

   localparam logic [2:0] OP_RD  = 3'd0;
   localparam logic [2:0] OP_WR  = 3'd1;
   localparam logic [2:0] OP_SRC = 3'd2;
   localparam logic [2:0] OP_ACK = 3'd3;
   localparam logic [2:0] OP_NOP = 3'd4;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [7:0]  d;
      logic [7:0]  exp;
      logic        xirq;
      logic        chk_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rd;
   logic        wr;
   logic [7:0]  rdata;
   logic        rvalid;
   logic [4:0]  int_src;
   logic        irq;
   logic        int_ack;
   logic [7:0]  vector;
   logic        vec_valid;

   int pass_cnt = 0;
   int total    = 0;

   logic [7:0] rq[$];
   logic [7:0] vq[$];
   vec_t       tbl[$];

   gb_interrupt_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .addr      (addr),
      .wdata     (wdata),
      .rd        (rd),
      .wr        (wr),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .int_src   (int_src),
      .irq       (irq),
      .int_ack   (int_ack),
      .vector    (vector),
      .vec_valid (vec_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         if (rq.size() == 0) begin
            total++;
            $display("FAIL rvalid_unexpected: got 1 want 0 at %0t", $time);
         end else begin
            chk("rdata", rdata, rq.pop_front());
         end
      end
      if (vec_valid === 1'b1) begin
         if (vq.size() == 0) begin
            total++;
            $display("FAIL vec_valid_unexpected: got 1 want 0 at %0t", $time);
         end else begin
            chk("vector", vector, vq.pop_front());
         end
      end
   end

   function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a,
                               input logic [7:0] d, input logic [7:0] exp,
                               input logic xirq, input logic chk_rd);
      vec_t v;
      v.op     = op;
      v.a      = a;
      v.d      = d;
      v.exp    = exp;
      v.xirq   = xirq;
      v.chk_rd = chk_rd;
      return v;
   endfunction

   task automatic idle_in();
      rd      = 1'b0;
      wr      = 1'b0;
      int_ack = 1'b0;
      int_src = 5'h00;
   endtask

   task automatic step(input vec_t v);
      idle_in();
      addr  = v.a;
      wdata = v.d;
      case (v.op)
         OP_RD: begin
            rd = 1'b1;
            if (v.a == IF_A || v.a == IE_A) rq.push_back(v.exp);
         end
         OP_WR:  wr = 1'b1;
         OP_SRC: int_src = v.d[4:0];
         OP_ACK: begin
            int_ack = 1'b1;
            vq.push_back(v.exp);
         end
         default: ;
      endcase
      @(posedge clk);
      #1;
      idle_in();
      chk("irq", {7'd0, irq}, {7'd0, v.xirq});
      if (v.chk_rd) chk("rdata_hold", rdata, v.exp);
   endtask

   initial begin
      logic [7:0] held_exp;
      reset = 1'b1;
      addr  = 16'h0000;
      wdata = 8'h00;
      idle_in();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      chk("rst_rvalid", {7'd0, rvalid}, 8'h00);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_vec_valid", {7'd0, vec_valid}, 8'h00);
      chk("rst_vector", vector, 8'h00);

      tbl.push_back(mk(OP_RD,  IF_A, 8'h00, 8'hE0, 1'b0, 1'b0));
      tbl.push_back(mk(OP_RD,  IE_A, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_WR,  IE_A, 8'h1F, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SRC, 16'h0, 8'h04, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_RD,  IF_A, 8'h00, 8'hE4, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ACK, 16'h0, 8'h00, 8'h50, 1'b1, 1'b0));
      tbl.push_back(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_RD,  IF_A, 8'h00, 8'hE0, 1'b0, 1'b0));
      tbl.push_back(mk(OP_SRC, 16'h0, 8'h13, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ACK, 16'h0, 8'h00, 8'h40, 1'b1, 1'b0));
      tbl.push_back(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ACK, 16'h0, 8'h00, 8'h48, 1'b1, 1'b0));
      tbl.push_back(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_ACK, 16'h0, 8'h00, 8'h60, 1'b1, 1'b0));
      tbl.push_back(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_WR,  IE_A, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_WR,  IF_A, 8'h01, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_ACK, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mk(OP_RD,  IF_A, 8'h00, 8'hE1, 1'b0, 1'b0));
      tbl.push_back(mk(OP_RD,  16'h1234, 8'h00, 8'hE1, 1'b0, 1'b1));
      tbl.push_back(mk(OP_WR,  IE_A, 8'hA5, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mk(OP_RD,  IE_A, 8'h00, 8'hA5, 1'b1, 1'b0));
      tbl.push_back(mk(OP_WR,  IF_A, 8'h00, 8'h00, 1'b0, 1'b0));

      for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

      // Source pulse on the grant-clear edge keeps IF[0] set.
      step(mk(OP_WR,  IE_A, 8'h1F, 8'h00, 1'b0, 1'b0));
      step(mk(OP_WR,  IF_A, 8'h01, 8'h00, 1'b1, 1'b0));
      step(mk(OP_ACK, 16'h0, 8'h00, 8'h40, 1'b1, 1'b0));
      step(mk(OP_SRC, 16'h0, 8'h01, 8'h00, 1'b1, 1'b0));
      step(mk(OP_RD,  IF_A, 8'h00, 8'hE1, 1'b1, 1'b0));

      // CPU clears IF in the ack cycle; granted vector is unaffected.
      step(mk(OP_WR,  IF_A, 8'h02, 8'h00, 1'b1, 1'b0));
      addr    = IF_A;
      wdata   = 8'h00;
      wr      = 1'b1;
      int_ack = 1'b1;
      vq.push_back(8'h48);
      @(posedge clk);
      #1;
      idle_in();
      chk("irq_wr_during_ack", {7'd0, irq}, 8'h00);
      step(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));

      // int_src held high for 10 cycles with a grant in the middle.
      for (int i = 0; i < 10; i++) begin
         int_src = 5'h01;
         int_ack = (i == 2);
         if (i == 2) vq.push_back(8'h40);
         @(posedge clk);
         #1;
         int_ack = 1'b0;
      end
      idle_in();
`ifdef IRQ_EDGE_DETECT_EN
      held_exp = 8'hE0;
`else
      held_exp = 8'hE1;
`endif
      chk("irq_after_held", {7'd0, irq}, {7'd0, held_exp[0]});
      step(mk(OP_RD, IF_A, 8'h00, held_exp, held_exp[0], 1'b0));

      // Reset asserted in the GRANT cycle aborts the grant.
      step(mk(OP_WR, IF_A, 8'h04, 8'h00, 1'b1, 1'b0));
      int_ack = 1'b1;
      @(posedge clk);
      #1;
      int_ack = 1'b0;
      reset   = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("abort_rvalid", {7'd0, rvalid}, 8'h00);
      chk("abort_rdata", rdata, 8'h00);
      chk("abort_irq", {7'd0, irq}, 8'h00);
      chk("abort_vec_valid", {7'd0, vec_valid}, 8'h00);
      chk("abort_vector", vector, 8'h00);
      step(mk(OP_RD, IF_A, 8'h00, 8'hE0, 1'b0, 1'b0));
      step(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));
      step(mk(OP_NOP, 16'h0, 8'h00, 8'h00, 1'b0, 1'b0));

      chk("rq_drained", 8'(rq.size()), 8'h00);
      chk("vq_drained", 8'(vq.size()), 8'h00);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/gb_interrupt_ctrl.md
GB_INTERRUPT_CTRL -- requirements
Module: gb_interrupt_ctrl

Interface
REQ-001 Parameter: IF_ADDR, 16'hFF0F, bus address of interrupt flag register.
REQ-002 Parameter: IE_ADDR, 16'hFFFF, bus address of interrupt enable register.
REQ-003 Parameter: VEC_BASE, 8'h40, vector of source 0; source n vector = VEC_BASE + 8*n.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 addr  in  16  bus address from CPU.
REQ-007 wdata  in  8  bus write data.
REQ-008 rd  in  1  read strobe, one cycle per access.
REQ-009 wr  in  1  write strobe, one cycle per access.
REQ-010 rdata  out  8  read data, valid when rvalid=1.
REQ-011 rvalid  out  1  pulses one cycle after rd hits IF_ADDR or IE_ADDR.
REQ-012 int_src  in  5  request sources [0]=VBLANK [1]=STAT [2]=TIMER [3]=SERIAL [4]=JOYPAD.
REQ-013 irq  out  1  high while (IE & IF & 5'h1F) != 0.
REQ-014 int_ack  in  1  CPU interrupt acknowledge, one-cycle pulse.
REQ-015 vector  out  8  ISR address low byte, valid when vec_valid=1.
REQ-016 vec_valid  out  1  one-cycle pulse carrying vector.

Function
REQ-017 IF is 5 bits; IE is 8 bits; reads of IF SHALL return {3'b111, IF}; reads of IE SHALL return all 8 bits.
REQ-018 Read latency SHALL be exactly 1 cycle; rd to any other address SHALL leave rvalid=0 and rdata unchanged.
REQ-019 A write to IF_ADDR SHALL load IF with wdata[4:0] on the next edge; a write to IE_ADDR SHALL load IE with wdata.
REQ-020 Source event on bit n SHALL set IF[n] on the next edge; event OR'd into a same-cycle CPU write value (event wins).
REQ-021 irq SHALL be combinational from IE and IF registers; no CPU enable gating inside block.
REQ-022 FSM states IDLE, GRANT; IDLE->GRANT on int_ack; GRANT->IDLE unconditionally after one cycle.
REQ-023 In IDLE with int_ack, block SHALL latch n = lowest set index of (IE & IF & 5'h1F), priority bit0 highest.
REQ-024 In GRANT, vec_valid=1, vector=VEC_BASE+8*n, and IF[n] SHALL clear on the GRANT->IDLE edge.
REQ-025 Same-cycle source event on bit n during the clear SHALL win; IF[n] stays 1.
REQ-026 int_ack with no enabled pending bit: GRANT issues vector=8'h00, vec_valid=1, IF unchanged.
REQ-027 int_ack while in GRANT SHALL be ignored.
REQ-028 Priority SHALL be sampled at int_ack; bits set after sampling do not change the granted vector.
REQ-029 Bus accesses SHALL proceed normally in either state; a CPU write clearing IF[n] during GRANT still yields granted vector.

Reset
REQ-030 On reset: IF=5'h00, IE=8'h00, FSM=IDLE, rvalid=0, rdata=8'h00, vec_valid=0, vector=8'h00, irq=0, edge-detect history=0.
REQ-031 Reset asserted during GRANT SHALL abort the grant: no vec_valid pulse, IF not cleared by the aborted grant.

Configuration
REQ-032 Macro IRQ_EDGE_DETECT_EN defined: int_src are levels; IF[n] sets only on 0->1 transition of int_src[n] (one registered history bit per source).
REQ-033 IRQ_EDGE_DETECT_EN undefined: int_src are pulses; IF[n] sets on every cycle int_src[n]=1; no history registers.

Verification
REQ-034 Reset, rd IF_ADDR -> rvalid next cycle, rdata=8'hE0; rd IE_ADDR -> rdata=8'h00.
REQ-035 wr IE=8'h1F, pulse int_src=5'b00100 -> IF=5'h04, irq=1; int_ack -> next cycle vec_valid=1, vector=8'h50; then IF=0, irq=0.
REQ-036 IE=8'h1F, int_src=5'b10011 same cycle, int_ack -> vector=8'h40; second int_ack -> 8'h48; third -> 8'h60.
REQ-037 IE=8'h00, IF=5'h01, int_ack -> irq=0 throughout, vector=8'h00, vec_valid=1, IF stays 5'h01.
REQ-038 IF[0] granted, int_src[0] pulses on clear edge -> IF[0]=1 after GRANT; with IRQ_EDGE_DETECT_EN, int_src held high 10 cycles -> IF[0] set once only.
REQ-039 int_ack then reset in GRANT cycle -> vec_valid never 1, all outputs at reset values next cycle.
